// File: rtl/regfile_pkg.sv
// Shared constants and writeback request type for the register file write port.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 31;

   // Bit positions of the two writeback sources in request/grant vectors
   localparam int GNT_ALU = 0;
   localparam int GNT_LD  = 1;

   typedef struct packed {
      logic [ADDR_W-1:0] rw;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; owns the LastLd priority flop.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [1:0] req,
   output logic [1:0] ready,
   output logic [1:0] gnt
);

   logic last_ld_reg;
   logic last_ld_next;

   // A source is ready unless the other one is asking and holds priority
   always_comb begin
      ready               = 2'b00;
      ready[GNT_ALU]      = Rst_n && (!req[GNT_LD] || last_ld_reg);
      ready[GNT_LD]       = Rst_n && (!req[GNT_ALU] || !last_ld_reg);
      gnt                 = req & ready;
      last_ld_next        = last_ld_reg;
      if (gnt[GNT_ALU]) begin
         last_ld_next = 1'b0;
      end else if (gnt[GNT_LD]) begin
         last_ld_next = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         last_ld_reg <= 1'b1;
      end else begin
         last_ld_reg <= last_ld_next;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32 x 64 register file (ALU vs load writeback).
// Optional same-cycle read bypass outputs enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              AluValid,
   output logic              AluReady,
   input  logic [ADDR_W-1:0] AluRW,
   input  logic [DATA_W-1:0] AluData,
   input  logic              LdValid,
   output logic              LdReady,
   input  logic [ADDR_W-1:0] LdRW,
   input  logic [DATA_W-1:0] LdData,
`ifdef REGFILE_WB_FWD_EN
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic              FwdA,
   output logic              FwdB,
   output logic [DATA_W-1:0] FwdData,
`endif
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   output logic              RegWr,
   output logic              Busy
);

   logic [1:0]        req;
   logic [1:0]        ready;
   logic [1:0]        gnt;
   logic              any_gnt;
   logic [ADDR_W-1:0] sel_rw;
   logic [DATA_W-1:0] sel_data;
   logic              reg_wr_reg;
   logic [ADDR_W-1:0] rw_reg;
   logic [DATA_W-1:0] busw_reg;

   assign req[regfile_pkg::GNT_ALU] = AluValid;
   assign req[regfile_pkg::GNT_LD]  = LdValid;

   rr_arb2 u_arb (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .req   (req),
      .ready (ready),
      .gnt   (gnt)
   );

   assign AluReady = ready[regfile_pkg::GNT_ALU];
   assign LdReady  = ready[regfile_pkg::GNT_LD];
   assign Busy     = AluValid && LdValid;

   assign any_gnt  = |gnt;
   assign sel_rw   = gnt[regfile_pkg::GNT_LD] ? LdRW   : AluRW;
   assign sel_data = gnt[regfile_pkg::GNT_LD] ? LdData : AluData;

   // X31 writes are still accepted and still load RW/BusW; only RegWr is suppressed
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         reg_wr_reg <= 1'b0;
         rw_reg     <= '0;
         busw_reg   <= '0;
      end else begin
         reg_wr_reg <= any_gnt && (sel_rw != ADDR_W'(ZERO_REG));
         if (any_gnt) begin
            rw_reg   <= sel_rw;
            busw_reg <= sel_data;
         end
      end
   end

   assign RegWr = reg_wr_reg;
   assign RW    = rw_reg;
   assign BusW  = busw_reg;

`ifdef REGFILE_WB_FWD_EN
   assign FwdA    = reg_wr_reg && (RA == rw_reg);
   assign FwdB    = reg_wr_reg && (RB == rw_reg);
   assign FwdData = busw_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic
// against a queue-based source model and an architectural register file model.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alu_valid, ld_valid;
   logic              alu_ready, ld_ready;
   logic [4:0]        alu_rw, ld_rw;
   logic [63:0]       alu_data, ld_data;
   logic [4:0]        rw;
   logic [63:0]       busw;
   logic              reg_wr;
   logic              busy;
`ifdef REGFILE_WB_FWD_EN
   logic [4:0]        ra, rb;
   logic              fwd_a, fwd_b;
   logic [63:0]       fwd_data;
`endif

   regfile_wb_arbiter dut (
      .Clk      (clk),
      .Rst_n    (rst_n),
      .AluValid (alu_valid),
      .AluReady (alu_ready),
      .AluRW    (alu_rw),
      .AluData  (alu_data),
      .LdValid  (ld_valid),
      .LdReady  (ld_ready),
      .LdRW     (ld_rw),
      .LdData   (ld_data),
`ifdef REGFILE_WB_FWD_EN
      .RA       (ra),
      .RB       (rb),
      .FwdA     (fwd_a),
      .FwdB     (fwd_b),
      .FwdData  (fwd_data),
`endif
      .RW       (rw),
      .BusW     (busw),
      .RegWr    (reg_wr),
      .Busy     (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Pending requests per source; the head is what the source currently presents
   wb_req_t alu_q[$];
   wb_req_t ld_q[$];

   // Reference state
   logic        started = 1'b0;
   logic        m_last_ld;
   logic        m_regwr;
   logic [4:0]  m_rw;
   logic [63:0] m_busw;
   logic [63:0] m_rf [32];
   logic [63:0] dut_rf [32];
   int          n_alu_gnt = 0;
   int          n_ld_gnt  = 0;

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_rf[i]   = '0;
         dut_rf[i] = '0;
      end
   end

   // Register file as the datapath sees it: commits whatever the DUT stages
   always @(posedge clk) begin
      if (reg_wr) dut_rf[rw] <= busw;
   end

   // Reference model: decides the winner from the grant rules and retires queue heads
   always @(posedge clk) begin
      logic win_alu, win_ld;
      started = 1'b1;
      if (!rst_n) begin
         m_last_ld = 1'b1;
         m_regwr   = 1'b0;
         m_rw      = '0;
         m_busw    = '0;
      end else begin
         win_alu = 1'b0;
         win_ld  = 1'b0;
         if (alu_valid && ld_valid) begin
            if (m_last_ld) win_alu = 1'b1;
            else           win_ld  = 1'b1;
         end else if (alu_valid) begin
            win_alu = 1'b1;
         end else if (ld_valid) begin
            win_ld = 1'b1;
         end
         m_regwr = 1'b0;
         if (win_alu) begin
            m_rw      = alu_rw;
            m_busw    = alu_data;
            m_regwr   = (alu_rw != 5'd31);
            m_last_ld = 1'b0;
            n_alu_gnt++;
            if (alu_q.size() > 0) void'(alu_q.pop_front());
         end else if (win_ld) begin
            m_rw      = ld_rw;
            m_busw    = ld_data;
            m_regwr   = (ld_rw != 5'd31);
            m_last_ld = 1'b1;
            n_ld_gnt++;
            if (ld_q.size() > 0) void'(ld_q.pop_front());
         end
         if (m_regwr) m_rf[m_rw] = m_busw;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (started) begin
         chk("RegWr", {63'd0, reg_wr}, {63'd0, m_regwr});
         chk("RW", {59'd0, rw}, {59'd0, m_rw});
         chk("BusW", busw, m_busw);
         chk("AluReady", {63'd0, alu_ready}, {63'd0, rst_n && !(ld_valid && !m_last_ld)});
         chk("LdReady", {63'd0, ld_ready}, {63'd0, rst_n && !(alu_valid && m_last_ld)});
         chk("Busy", {63'd0, busy}, {63'd0, alu_valid && ld_valid});
`ifdef REGFILE_WB_FWD_EN
         chk("FwdA", {63'd0, fwd_a}, {63'd0, m_regwr && (ra == m_rw)});
         chk("FwdB", {63'd0, fwd_b}, {63'd0, m_regwr && (rb == m_rw)});
         chk("FwdData", fwd_data, m_busw);
`endif
      end
   end

   task automatic present();
      alu_valid = (alu_q.size() > 0);
      if (alu_valid) begin
         alu_rw   = alu_q[0].rw;
         alu_data = alu_q[0].data;
      end
      ld_valid = (ld_q.size() > 0);
      if (ld_valid) begin
         ld_rw   = ld_q[0].rw;
         ld_data = ld_q[0].data;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      present();
   endtask

   function automatic wb_req_t mk(input int r, input logic [63:0] d);
      wb_req_t q;
      q.rw   = 5'(r);
      q.data = d;
      return q;
   endfunction

   function automatic wb_req_t rnd_req();
      wb_req_t q;
      q.rw   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      q.data = {$urandom, $urandom};
      return q;
   endfunction

   initial begin
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      alu_rw    = '0;
      ld_rw     = '0;
      alu_data  = '0;
      ld_data   = '0;
`ifdef REGFILE_WB_FWD_EN
      ra = '0;
      rb = '0;
`endif
      // Reset with both sources already valid, then contention A,B,A,B
      alu_q.push_back(mk(1, 64'd1));
      alu_q.push_back(mk(1, 64'd2));
      ld_q.push_back(mk(2, 64'd10));
      ld_q.push_back(mk(2, 64'd11));
      present();
      repeat (2) cycle();
      chk("rst_RegWr", {63'd0, reg_wr}, 64'd0);
      chk("rst_RW", {59'd0, rw}, 64'd0);
      chk("rst_BusW", busw, 64'd0);
      chk("rst_AluReady", {63'd0, alu_ready}, 64'd0);
      chk("rst_LdReady", {63'd0, ld_ready}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("first_AluReady", {63'd0, alu_ready}, 64'd1);
      chk("first_LdReady", {63'd0, ld_ready}, 64'd0);
      cycle();
      chk("c1_RW", {59'd0, rw}, 64'd1);
      chk("c1_BusW", busw, 64'd1);
      cycle();
      chk("c2_RW", {59'd0, rw}, 64'd2);
      chk("c2_BusW", busw, 64'd10);
      cycle();
      chk("c3_BusW", busw, 64'd2);
      cycle();
      chk("c4_BusW", busw, 64'd11);
      cycle();
      chk("rf1", dut_rf[1], 64'd2);
      chk("rf2", dut_rf[2], 64'd11);

      // Zero register write: accepted, discarded, still flips priority
      ld_q.push_back(mk(31, 64'hFFFF));
      present();
      #1;
      chk("x31_LdReady", {63'd0, ld_ready}, 64'd1);
      cycle();
      chk("x31_RegWr", {63'd0, reg_wr}, 64'd0);
      cycle();
      chk("rf31", dut_rf[31], 64'd0);
      alu_q.push_back(mk(3, 64'hAAA));
      ld_q.push_back(mk(4, 64'hBBB));
      present();
      #1;
      chk("post31_AluReady", {63'd0, alu_ready}, 64'd1);
      chk("post31_LdReady", {63'd0, ld_ready}, 64'd0);
      cycle();
      chk("post31_RW", {59'd0, rw}, 64'd3);
      repeat (2) cycle();

      // Single source write followed by idle hold
      alu_q.push_back(mk(5, 64'h12345678));
      present();
      #1;
      chk("single_AluReady", {63'd0, alu_ready}, 64'd1);
      cycle();
      chk("single_RegWr", {63'd0, reg_wr}, 64'd1);
      chk("single_RW", {59'd0, rw}, 64'd5);
      chk("single_BusW", busw, 64'h12345678);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("idle_RegWr", {63'd0, reg_wr}, 64'd0);
         chk("idle_RW", {59'd0, rw}, 64'd5);
         chk("idle_BusW", busw, 64'h12345678);
      end
      chk("rf5", dut_rf[5], 64'h12345678);

`ifdef REGFILE_WB_FWD_EN
      alu_q.push_back(mk(7, 64'hAA));
      present();
      cycle();
      ra = 5'd7;
      rb = 5'd8;
      #1;
      chk("fwd_FwdA", {63'd0, fwd_a}, 64'd1);
      chk("fwd_FwdData", fwd_data, 64'hAA);
      chk("fwd_FwdB", {63'd0, fwd_b}, 64'd0);
      cycle();
`endif

      // Randomized traffic with one reset pulse in the middle
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk);
         #1;
         rst_n = !(n >= 1000 && n < 1002);
         if (alu_q.size() == 0 && $urandom_range(0, 3) != 0) alu_q.push_back(rnd_req());
         if (ld_q.size() == 0 && $urandom_range(0, 3) != 0) ld_q.push_back(rnd_req());
`ifdef REGFILE_WB_FWD_EN
         ra = ($urandom_range(0, 1) == 0) ? m_rw : 5'($urandom_range(0, 31));
         rb = 5'($urandom_range(0, 31));
`endif
         present();
      end
      rst_n = 1'b1;
      for (int k = 0; k < 50 && (alu_q.size() > 0 || ld_q.size() > 0); k++) cycle();
      if (alu_q.size() > 0 || ld_q.size() > 0) begin
         chk("drain_pending", 64'(alu_q.size() + ld_q.size()), 64'd0);
      end
      repeat (2) cycle();
      for (int i = 0; i < 32; i++) chk($sformatf("rf_final[%0d]", i), dut_rf[i], m_rf[i]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
